reg_stream_master: RTL and testbench

Sequential command issuer that sits directly upstream of the Regbus-to-AXI4 adapter. It accepts single register access commands on a valid/ready stream and drives them one at a time onto the Regbus request port. It holds each request stable until the Regbus `ready`, then returns read data and status on a buffered valid/ready response stream. A programmable timeout aborts accesses that never complete.

---
 rtl/reg_stream_master_pkg.sv | 41 ++++
 rtl/reg_stream_master.sv | 126 ++++++++++++
 tb/tb_reg_stream_master.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_stream_master_pkg.sv
// Shared types for reg_stream_master: the FSM state encoding, the buffered
// response record and the default Regbus request/response structs.
package reg_stream_master_pkg;

  localparam int unsigned AddrWidthDef = 32;
  localparam int unsigned DataWidthDef = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DataWidthDef-1:0] rdata;
    logic                    error;
    logic                    timeout;
  } rsp_t;

  typedef struct packed {
    logic [AddrWidthDef-1:0]   addr;
    logic                      write;
    logic [DataWidthDef-1:0]   wdata;
    logic [DataWidthDef/8-1:0] wstrb;
    logic                      valid;
  } reg_req_default_t;

  typedef struct packed {
    logic [DataWidthDef-1:0] rdata;
    logic                    error;
    logic                    ready;
  } reg_rsp_default_t;

  // Wide enough to hold TimeoutCycles itself; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
    int unsigned w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_stream_master.sv
// Single-outstanding Regbus command issuer: command stream in, one Regbus
// access at a time, buffered response stream out, with an access timeout.
module reg_stream_master
  import reg_stream_master_pkg::*;
#(
  parameter int unsigned AddrWidth     = AddrWidthDef,
  parameter int unsigned DataWidth     = DataWidthDef,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type         reg_req_t     = reg_req_default_t,
  parameter type         reg_rsp_t     = reg_rsp_default_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic                   cmd_write_i,
  input  logic [DataWidth-1:0]   cmd_wdata_i,
  input  logic [DataWidth/8-1:0] cmd_wstrb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic                   rsp_timeout_o,
  output reg_req_t               reg_req_o,
  input  reg_rsp_t               reg_rsp_i,
  output logic                   busy_o
);

  localparam int unsigned CntW     = cnt_width(TimeoutCycles);
  localparam int unsigned LimitInt = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(LimitInt);
  localparam logic [CntW-1:0] CntMax   = '1;
  localparam bit TimeoutEn = (TimeoutCycles != 0);

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [DataWidth/8-1:0] wstrb_q, wstrb_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  rsp_t                   rsp_q, rsp_d;

  // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          write_d = cmd_write_i;
          wdata_d = cmd_write_i ? cmd_wdata_i : '0;
          wstrb_d = cmd_write_i ? cmd_wstrb_i : '0;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // A ready landing on the limit cycle still completes normally.
        if (reg_rsp_i.ready) begin
          rsp_d.rdata   = write_q ? '0 : reg_rsp_i.rdata;
          rsp_d.error   = reg_rsp_i.error;
          rsp_d.timeout = 1'b0;
          state_d       = RESP;
        end else if (TimeoutEn && (cnt_q == CntLimit)) begin
          rsp_d.rdata   = '0;
          rsp_d.error   = 1'b1;
          rsp_d.timeout = 1'b1;
          state_d       = RESP;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  // Outputs depend only on flops; reg_rsp_i never reaches an output combinationally.
  always_comb begin
    reg_req_o       = '0;
    reg_req_o.addr  = addr_q;
    reg_req_o.write = write_q;
    reg_req_o.wdata = wdata_q;
    reg_req_o.wstrb = wstrb_q;
    reg_req_o.valid = (state_q == BUS);
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rsp_q.rdata;
  assign rsp_error_o   = rsp_q.error;
  assign rsp_timeout_o = rsp_q.timeout;

endmodule

// File: tb/tb_reg_stream_master.sv
// Directed self-checking bench for reg_stream_master with an 8-cycle timeout.
module tb_reg_stream_master;
  import reg_stream_master_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_addr;
  logic             cmd_write;
  logic [31:0]      cmd_wdata;
  logic [3:0]       cmd_wstrb;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_rdata;
  logic             rsp_error;
  logic             rsp_timeout;
  reg_req_default_t reg_req;
  reg_rsp_default_t reg_rsp;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  reg_stream_master #(
    .AddrWidth    (32),
    .DataWidth    (32),
    .TimeoutCycles(8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_write_i  (cmd_write),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_wstrb_i  (cmd_wstrb),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_error_o  (rsp_error),
    .rsp_timeout_o(rsp_timeout),
    .reg_req_o    (reg_req),
    .reg_rsp_i    (reg_rsp),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s);
    check("issue_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_wstrb = s;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n_valid;
    logic [31:0] held;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    rsp_ready = 1'b0;
    reg_rsp   = '0;
    #12;
    check("rst_req", reg_req, '0);
    check("rst_rsp", {rsp_valid, rsp_rdata, rsp_error, rsp_timeout, busy}, '0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    step();

    // Single write, ready on the second BUS cycle; rdata must be forced to 0.
    issue(32'h100, 1'b1, 32'hDEADBEEF, 4'hF);
    check("wr_req_c1", {reg_req.valid, reg_req.write, reg_req.addr, reg_req.wdata, reg_req.wstrb},
          {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
    step();
    check("wr_req_c2", {reg_req.valid, reg_req.write, reg_req.addr, reg_req.wdata, reg_req.wstrb},
          {1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
    check("wr_no_rsp_yet", rsp_valid, 1'b0);
    reg_rsp = '{rdata: 32'hAAAA5555, error: 1'b0, ready: 1'b1};
    step();
    reg_rsp = '0;
    check("wr_rsp", {rsp_valid, rsp_rdata, rsp_error, rsp_timeout, reg_req.valid},
          {1'b1, 32'h0, 1'b0, 1'b0, 1'b0});
    finish_rsp();
    check("wr_back_idle", {cmd_ready, busy}, 2'b10);

    // Single read, ready in the first BUS cycle; wdata/wstrb captured as 0.
    issue(32'h204, 1'b0, 32'hFFFFFFFF, 4'hF);
    check("rd_req", {reg_req.valid, reg_req.write, reg_req.addr, reg_req.wdata, reg_req.wstrb},
          {1'b1, 1'b0, 32'h204, 32'h0, 4'h0});
    reg_rsp = '{rdata: 32'h12345678, error: 1'b0, ready: 1'b1};
    step();
    reg_rsp = '0;
    check("rd_rsp", {rsp_valid, rsp_rdata, rsp_error, rsp_timeout},
          {1'b1, 32'h12345678, 1'b0, 1'b0});
    finish_rsp();
    check("rd_idle", cmd_ready, 1'b1);

    // Response backpressure while a second command waits.
    issue(32'h300, 1'b0, 32'h0, 4'h0);
    reg_rsp = '{rdata: 32'hCAFEF00D, error: 1'b0, ready: 1'b1};
    step();
    reg_rsp   = '0;
    cmd_valid = 1'b1;
    cmd_addr  = 32'h304;
    cmd_write = 1'b0;
    held      = rsp_rdata;
    check("bp_first_rdata", held, 32'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      check("bp_cmd_ready", cmd_ready, 1'b0);
      check("bp_rsp_held", {rsp_valid, rsp_rdata}, {1'b1, 32'hCAFEF00D});
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_ready_after", {cmd_ready, rsp_valid}, 2'b10);
    step();
    cmd_valid = 1'b0;
    check("bp_second_accepted", {reg_req.valid, reg_req.addr}, {1'b1, 32'h304});
    reg_rsp = '{rdata: 32'h0, error: 1'b0, ready: 1'b1};
    step();
    reg_rsp = '0;
    finish_rsp();

    // Timeout: ready never arrives.
    issue(32'h400, 1'b0, 32'h0, 4'h0);
    n_valid = 0;
    while (reg_req.valid && n_valid < 40) begin
      n_valid++;
      step();
    end
    check("to_valid_cycles", 64'(n_valid), 64'd8);
    check("to_rsp", {rsp_valid, rsp_rdata, rsp_error, rsp_timeout},
          {1'b1, 32'h0, 1'b1, 1'b1});
    finish_rsp();

    // Ready arriving on the 8th BUS cycle wins over the timeout.
    issue(32'h404, 1'b0, 32'h0, 4'h0);
    repeat (7) step();
    check("to8_still_valid", reg_req.valid, 1'b1);
    reg_rsp = '{rdata: 32'h00000055, error: 1'b0, ready: 1'b1};
    step();
    reg_rsp = '0;
    check("to8_rsp", {rsp_valid, rsp_rdata, rsp_error, rsp_timeout},
          {1'b1, 32'h55, 1'b0, 1'b0});
    finish_rsp();

    // Error passthrough.
    issue(32'h500, 1'b0, 32'h0, 4'h0);
    reg_rsp = '{rdata: 32'h0BAD0BAD, error: 1'b1, ready: 1'b1};
    step();
    reg_rsp = '0;
    check("err_rsp", {rsp_valid, rsp_rdata, rsp_error, rsp_timeout},
          {1'b1, 32'h0BAD0BAD, 1'b1, 1'b0});
    finish_rsp();

    // Reset during BUS acts without a clock edge and leaves no response behind.
    issue(32'h600, 1'b0, 32'h0, 4'h0);
    check("rst_mid_in_bus", reg_req.valid, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_async", {reg_req.valid, busy, cmd_ready}, 3'b001);
    #2;
    rst     = 1'b0;
    reg_rsp = '{rdata: 32'h1, error: 1'b0, ready: 1'b1};
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mid_no_rsp", {rsp_valid, busy, cmd_ready}, 3'b001);
    end
    reg_rsp = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
